// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: operation encodings.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a circular buffer whose oldest entry is overwritten
// on push-when-full, with combinational overflow/underflow indications.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign top       = entries[ptr - PTR_W'(1)];
  assign overflow  = push && full;
  assign underflow = pop && empty;

  // NOTE: the entry array is deliberately left out of reset; it is only read
  // when count is non-zero, so clearing it would add reset fanout for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[ptr] <= push_data;
    end
  end

  // ptr names the next free slot; when full it also names the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential, branch, jump, call and return redirection
// backed by a small return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int RESET_VECTOR = 0,
  parameter int PC_INC       = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [2:0]           op,
  input  logic [BUS_WIDTH-1:0] target,
  input  logic [BUS_WIDTH-1:0] offset,
  output logic [BUS_WIDTH-1:0] pc,
  output logic [BUS_WIDTH-1:0] pc_plus,
  output logic                 ras_empty,
  output logic                 ras_full,
  output logic                 ras_err
);

  logic [BUS_WIDTH-1:0] pc_next;
  logic [BUS_WIDTH-1:0] ras_top;
  logic                 push;
  logic                 pop;
  logic                 overflow;
  logic                 underflow;

  assign pc_plus = pc + BUS_WIDTH'(PC_INC);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next = pc_plus;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall) begin
      case (op_e'(op))
        OP_BRANCH: pc_next = pc + offset;
        OP_JUMP:   pc_next = target;
        OP_CALL: begin
          pc_next = target;
          push    = 1'b1;
        end
        OP_RET: begin
          pop = 1'b1;
          if (!ras_empty) begin
            pc_next = ras_top;
          end
        end
        default:   pc_next = pc_plus;
      endcase
    end
  end

  pc_ras #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= BUS_WIDTH'(RESET_VECTOR);
      ras_err <= 1'b0;
    end else if (stall) begin
      ras_err <= 1'b0;
    end else begin
      pc      <= pc_next;
      ras_err <= overflow || underflow;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver queues hand-computed expectations
// per clock, a monitor pops and compares them on the falling edge.
module tb_pc_unit;
  import pc_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] target = '0;
  logic [15:0] offset = '0;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int compared   = 0;
  int mismatched = 0;
  exp_t sb[$];

  pc_unit #(
    .BUS_WIDTH    (16),
    .RESET_VECTOR (16'h0100),
    .PC_INC       (1),
    .RAS_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new registered state after every edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".pc"},      pc,        e.pc);
      check({e.name, ".pc_plus"}, pc_plus,   e.pc + 16'd1);
      check({e.name, ".empty"},   16'(ras_empty), 16'(e.empty));
      check({e.name, ".full"},    16'(ras_full),  16'(e.full));
      check({e.name, ".err"},     16'(ras_err),   16'(e.err));
    end
  end

  task automatic step(input string name, input logic r, input logic s, input logic [2:0] o,
                      input logic [15:0] tgt, input logic [15:0] off,
                      input logic [15:0] e_pc, input logic e_empty, input logic e_full,
                      input logic e_err);
    exp_t e;
    rst = r; stall = s; op = o; target = tgt; offset = off;
    @(posedge clk);
    #1;
    e.name = name; e.pc = e_pc; e.empty = e_empty; e.full = e_full; e.err = e_err;
    sb.push_back(e);
  endtask

  initial begin
    // Sequential stepping.
    step("reset",  1, 0, OP_NEXT,   0, 0, 16'h0100, 1, 0, 0);
    step("next1",  0, 0, OP_NEXT,   0, 0, 16'h0101, 1, 0, 0);
    step("next2",  0, 0, OP_NEXT,   0, 0, 16'h0102, 1, 0, 0);
    step("next3",  0, 0, OP_NEXT,   0, 0, 16'h0103, 1, 0, 0);
    // Branch backwards and wrap at the top of the address space.
    step("branch", 0, 0, OP_BRANCH, 0, 16'hFFFE, 16'h0101, 1, 0, 0);
    step("jmp_top",0, 0, OP_JUMP,   16'hFFFF, 0, 16'hFFFF, 1, 0, 0);
    step("wrap",   0, 0, OP_NEXT,   0, 0, 16'h0000, 1, 0, 0);
    step("rsvd7",  0, 0, 3'd7,      16'h0555, 16'h0555, 16'h0001, 1, 0, 0);
    // Call and return.
    step("jmp101", 0, 0, OP_JUMP,   16'h0101, 0, 16'h0101, 1, 0, 0);
    step("call",   0, 0, OP_CALL,   16'h0200, 0, 16'h0200, 0, 0, 0);
    step("ret",    0, 0, OP_RET,    0, 0, 16'h0102, 1, 0, 0);
    // Overflow then underflow.
    step("rst2",   1, 0, OP_NEXT,   0, 0, 16'h0100, 1, 0, 0);
    step("jmp1k",  0, 0, OP_JUMP,   16'h1000, 0, 16'h1000, 1, 0, 0);
    step("call2k", 0, 0, OP_CALL,   16'h2000, 0, 16'h2000, 0, 0, 0);
    step("call3k", 0, 0, OP_CALL,   16'h3000, 0, 16'h3000, 0, 0, 0);
    step("call4k", 0, 0, OP_CALL,   16'h4000, 0, 16'h4000, 0, 0, 0);
    step("call5k", 0, 0, OP_CALL,   16'h5000, 0, 16'h5000, 0, 1, 0);
    step("call6k", 0, 0, OP_CALL,   16'h6000, 0, 16'h6000, 0, 1, 1);
    step("ret1",   0, 0, OP_RET,    0, 0, 16'h5001, 0, 0, 0);
    step("ret2",   0, 0, OP_RET,    0, 0, 16'h4001, 0, 0, 0);
    step("ret3",   0, 0, OP_RET,    0, 0, 16'h3001, 0, 0, 0);
    step("ret4",   0, 0, OP_RET,    0, 0, 16'h2001, 1, 0, 0);
    step("ret5",   0, 0, OP_RET,    0, 0, 16'h2002, 1, 0, 1);
    step("after",  0, 0, OP_NEXT,   0, 0, 16'h2003, 1, 0, 0);
    // Stall holds state, including an underflowing RET; reset beats stall.
    step("stall1", 0, 1, OP_JUMP,   16'h0300, 0, 16'h2003, 1, 0, 0);
    step("stall2", 0, 1, OP_JUMP,   16'h0300, 0, 16'h2003, 1, 0, 0);
    step("stall3", 0, 1, OP_JUMP,   16'h0300, 0, 16'h2003, 1, 0, 0);
    step("stallrt",0, 1, OP_RET,    0, 0, 16'h2003, 1, 0, 0);
    step("rststl", 1, 1, OP_JUMP,   16'h0300, 0, 16'h0100, 1, 0, 0);
    // Reset discards stacked entries.
    step("callA",  0, 0, OP_CALL,   16'h0500, 0, 16'h0500, 0, 0, 0);
    step("callB",  0, 0, OP_CALL,   16'h0600, 0, 16'h0600, 0, 0, 0);
    step("rst3",   1, 0, OP_NEXT,   0, 0, 16'h0100, 1, 0, 0);
    step("retE",   0, 0, OP_RET,    0, 0, 16'h0101, 1, 0, 1);
    step("idle",   0, 0, OP_NEXT,   0, 0, 16'h0102, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
